// File: rtl/controller_fsm.sv
// Multicycle byte-fetch controller: four fetch cycles, decode, then per-class execute states.
// Optional ADDI path enabled by defining CONTROLLER_ADDI_EN.
module controller_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic       alusrca,
    output logic       pcen,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic [2:0] alucontrol,
    output logic [3:0] irwrite
);

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
`ifdef CONTROLLER_ADDI_EN
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14,
`endif
        S_JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q;
    state_t state_d;
    logic   pcwrite_s;
    logic   branch_s;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = S_FETCH1;
        case (state_q)
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FETCH3;
            S_FETCH3: state_d = S_FETCH4;
            S_FETCH4: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LB:    state_d = S_MEMADR;
                    OP_SB:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_RTYPEEX;
                    OP_BEQ:   state_d = S_BEQEX;
                    OP_J:     state_d = S_JEX;
`ifdef CONTROLLER_ADDI_EN
                    OP_ADDI:  state_d = S_ADDIEX;
`endif
                    default:  state_d = S_FETCH1;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LB) begin
                    state_d = S_LBRD;
                end else begin
                    state_d = S_SBWR;
                end
            end
            S_LBRD:    state_d = S_LBWR;
            S_RTYPEEX: state_d = S_RTYPEWR;
`ifdef CONTROLLER_ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWR;
`endif
            default:   state_d = S_FETCH1;
        endcase
    end

    // Output decode; pcen folds in the branch condition in the same cycle
    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsource   = 2'b00;
        alucontrol = 3'b000;
        irwrite    = 4'b0000;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        case (state_q)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                memread    = 1'b1;
                iord       = 1'b1;
                alusrca    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                pcwrite_s  = 1'b1;
                irwrite    = 4'b0001 << state_q[1:0];
            end
            S_DECODE: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
            end
            S_MEMADR: begin
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            S_LBRD: memread = 1'b1;
            S_LBWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_SBWR: memwrite = 1'b1;
            S_RTYPEEX: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            S_RTYPEWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_BEQEX: begin
                alucontrol = 3'b110;
                pcsource   = 2'b01;
                branch_s   = 1'b1;
            end
            S_JEX: begin
                pcwrite_s = 1'b1;
                pcsource  = 2'b10;
            end
`ifdef CONTROLLER_ADDI_EN
            S_ADDIEX: begin
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            S_ADDIWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                memtoreg = 1'b1;
            end
`endif
            default: begin
                pcwrite_s = 1'b0;
            end
        endcase
        pcen = pcwrite_s | (branch_s & zero);
    end

endmodule
